// File: rtl/controlador_entrada_io.sv
// controlador_entrada_io
// Responder side of the CPU IN command. It collects up to three decimal
// digits from the switches, one debounced button press per key. The digits
// are echoed as BCD for the seven-segment drivers. The binary value goes
// back to the CPU through a 4-phase request/ready (req_in/pronto) handshake.

module controlador_entrada_io #(
   parameter int         LARGURA_DADO = 32,
   parameter logic [3:0] COD_ENTER    = 4'hA,
   parameter logic [3:0] COD_APAGA    = 4'hB
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_in,
   input  logic [3:0]              dado_chaves,
   input  logic                    botao,
   output logic [LARGURA_DADO-1:0] dado_lido,
   output logic                    pronto,
   output logic                    aguardando,
   output logic                    erro,
   output logic [3:0]              bcd_uni,
   output logic [3:0]              bcd_dez,
   output logic [3:0]              bcd_cen
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ESPERA   = 2'd1,
      CONVERTE = 2'd2,
      ENTREGA  = 2'd3
   } estado_t;

   estado_t                 state_q, state_d;
   logic [LARGURA_DADO-1:0] dado_lido_q, dado_lido_d;
   logic                    pronto_q, pronto_d;
   logic                    aguardando_q, aguardando_d;
   logic                    erro_q, erro_d;
   logic [3:0]              uni_q, uni_d;
   logic [3:0]              dez_q, dez_d;
   logic [3:0]              cen_q, cen_d;
   logic [1:0]              count_q, count_d;
   logic                    botao_ant_q, botao_ant_d;

   logic                    press;
   logic [9:0]              valor;

   // A press is a rising edge of the debounced button. A button already held
   // when ESPERA is entered therefore needs a release before it counts.
   always_comb begin
      press = botao & ~botao_ant_q;
   end

   // Decimal-to-binary conversion of the three displayed digits (max 999).
   always_comb begin
      valor = (10'(cen_q) * 10'd100) + (10'(dez_q) * 10'd10) + 10'(uni_q);
   end

   // Next-state and output logic for the entry/handshake sequencer.
   always_comb begin
      state_d      = state_q;
      dado_lido_d  = dado_lido_q;
      pronto_d     = pronto_q;
      aguardando_d = aguardando_q;
      erro_d       = 1'b0;
      uni_d        = uni_q;
      dez_d        = dez_q;
      cen_d        = cen_q;
      count_d      = count_q;
      botao_ant_d  = botao;

      case (state_q)
         OCIOSO: begin
            if (req_in) begin
               state_d      = ESPERA;
               uni_d        = 4'd0;
               dez_d        = 4'd0;
               cen_d        = 4'd0;
               count_d      = 2'd0;
               aguardando_d = 1'b1;
            end
         end

         ESPERA: begin
            if (!req_in) begin
               state_d      = OCIOSO;
               uni_d        = 4'd0;
               dez_d        = 4'd0;
               cen_d        = 4'd0;
               count_d      = 2'd0;
               aguardando_d = 1'b0;
            end else if (press) begin
               if (dado_chaves <= 4'd9) begin
                  if (count_q != 2'd3) begin
                     cen_d   = dez_q;
                     dez_d   = uni_q;
                     uni_d   = dado_chaves;
                     count_d = count_q + 2'd1;
                  end else begin
                     erro_d = 1'b1;
                  end
               end else if (dado_chaves == COD_APAGA) begin
                  if (count_q != 2'd0) begin
                     uni_d   = dez_q;
                     dez_d   = cen_q;
                     cen_d   = 4'd0;
                     count_d = count_q - 2'd1;
                  end else begin
                     erro_d = 1'b1;
                  end
               end else if (dado_chaves == COD_ENTER) begin
                  if (count_q != 2'd0) begin
                     state_d = CONVERTE;
                  end else begin
                     erro_d = 1'b1;
                  end
               end else begin
                  erro_d = 1'b1;
               end
            end
         end

         CONVERTE: begin
            if (!req_in) begin
               state_d      = OCIOSO;
               uni_d        = 4'd0;
               dez_d        = 4'd0;
               cen_d        = 4'd0;
               count_d      = 2'd0;
               aguardando_d = 1'b0;
            end else begin
               state_d      = ENTREGA;
               dado_lido_d  = LARGURA_DADO'(valor);
               pronto_d     = 1'b1;
               aguardando_d = 1'b0;
            end
         end

         ENTREGA: begin
            if (!req_in) begin
               state_d  = OCIOSO;
               pronto_d = 1'b0;
            end
         end

         default: begin
            state_d = OCIOSO;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= OCIOSO;
         dado_lido_q  <= '0;
         pronto_q     <= 1'b0;
         aguardando_q <= 1'b0;
         erro_q       <= 1'b0;
         uni_q        <= 4'd0;
         dez_q        <= 4'd0;
         cen_q        <= 4'd0;
         count_q      <= 2'd0;
         botao_ant_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         dado_lido_q  <= dado_lido_d;
         pronto_q     <= pronto_d;
         aguardando_q <= aguardando_d;
         erro_q       <= erro_d;
         uni_q        <= uni_d;
         dez_q        <= dez_d;
         cen_q        <= cen_d;
         count_q      <= count_d;
         botao_ant_q  <= botao_ant_d;
      end
   end

   assign dado_lido  = dado_lido_q;
   assign pronto     = pronto_q;
   assign aguardando = aguardando_q;
   assign erro       = erro_q;
   assign bcd_uni    = uni_q;
   assign bcd_dez    = dez_q;
   assign bcd_cen    = cen_q;

endmodule

// File: tb/tb_controlador_entrada_io.sv
// Directed self-checking bench for controlador_entrada_io.

module tb_controlador_entrada_io;

   localparam int         LARGURA_DADO = 32;
   localparam logic [3:0] COD_ENTER    = 4'hA;
   localparam logic [3:0] COD_APAGA    = 4'hB;

   logic                    clock;
   logic                    reset;
   logic                    req_in;
   logic [3:0]              dado_chaves;
   logic                    botao;
   logic [LARGURA_DADO-1:0] dado_lido;
   logic                    pronto;
   logic                    aguardando;
   logic                    erro;
   logic [3:0]              bcd_uni;
   logic [3:0]              bcd_dez;
   logic [3:0]              bcd_cen;

   int vectors;
   int miscompares;

   controlador_entrada_io #(
      .LARGURA_DADO(LARGURA_DADO),
      .COD_ENTER   (COD_ENTER),
      .COD_APAGA   (COD_APAGA)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_in     (req_in),
      .dado_chaves(dado_chaves),
      .botao      (botao),
      .dado_lido  (dado_lido),
      .pronto     (pronto),
      .aguardando (aguardando),
      .erro       (erro),
      .bcd_uni    (bcd_uni),
      .bcd_dez    (bcd_dez),
      .bcd_cen    (bcd_cen)
   );

   // 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance one posedge; outputs are sampled and inputs changed 1 ns later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One button press on key k: pressed for one edge, released for one edge.
   // erro_seen holds erro right after the edge that samples the press.
   task automatic press_key(input logic [3:0] k, output logic erro_seen);
      dado_chaves = k;
      botao       = 1'b1;
      tick();
      erro_seen   = erro;
      botao       = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic e;
      reset = 1'b0; req_in = 1'b0; botao = 1'b0; dado_chaves = 4'd0;
      tick(); tick();
      reset = 1'b1;
      tick();
      vectors++;
      if (dado_lido !== 32'd0 || pronto !== 1'b0 || aguardando !== 1'b0 || erro !== 1'b0) begin
         $display("[TB] FAIL reset_outputs: dado_lido=%0d pronto=%b aguardando=%b erro=%b, expected 0/0/0/0",
                  dado_lido, pronto, aguardando, erro);
         miscompares++;
      end
      vectors++;
      if ({bcd_cen, bcd_dez, bcd_uni} !== 12'h000) begin
         $display("[TB] FAIL reset_bcd: got %h%h%h, expected 000", bcd_cen, bcd_dez, bcd_uni);
         miscompares++;
      end
      press_key(4'd5, e);
      vectors++;
      if (e !== 1'b0 || bcd_uni !== 4'd0 || aguardando !== 1'b0) begin
         $display("[TB] FAIL idle_press: erro=%b uni=%0d aguardando=%b, expected 0/0/0", e, bcd_uni, aguardando);
         miscompares++;
      end
   endtask

   task automatic test_basic_entry();
      logic e;
      req_in = 1'b1;
      tick();
      vectors++;
      if (aguardando !== 1'b1) begin
         $display("[TB] FAIL aguardando_on: got %b, expected 1", aguardando);
         miscompares++;
      end
      press_key(4'd1, e);
      press_key(4'd2, e);
      vectors++;
      if ({bcd_dez, bcd_uni} !== 8'h12) begin
         $display("[TB] FAIL two_digits: got %h%h, expected 12", bcd_dez, bcd_uni);
         miscompares++;
      end
      press_key(4'd3, e);
      vectors++;
      if ({bcd_cen, bcd_dez, bcd_uni} !== 12'h123 || aguardando !== 1'b1) begin
         $display("[TB] FAIL digits_123: got %h%h%h aguardando=%b, expected 123 aguardando=1",
                  bcd_cen, bcd_dez, bcd_uni, aguardando);
         miscompares++;
      end
      dado_chaves = COD_ENTER;
      botao = 1'b1;
      tick();
      vectors++;
      if (pronto !== 1'b0) begin
         $display("[TB] FAIL pronto_early: got %b after ENTER edge, expected 0", pronto);
         miscompares++;
      end
      botao = 1'b0;
      tick();
      vectors++;
      if (pronto !== 1'b1 || dado_lido !== 32'd123 || aguardando !== 1'b0) begin
         $display("[TB] FAIL deliver_123: pronto=%b dado_lido=%0d aguardando=%b, expected 1/123/0",
                  pronto, dado_lido, aguardando);
         miscompares++;
      end
      tick(); tick();
      vectors++;
      if (pronto !== 1'b1) begin
         $display("[TB] FAIL pronto_hold: got %b, expected 1", pronto);
         miscompares++;
      end
      req_in = 1'b0;
      tick();
      vectors++;
      if (pronto !== 1'b0 || dado_lido !== 32'd123 || bcd_uni !== 4'd3) begin
         $display("[TB] FAIL handshake_end: pronto=%b dado_lido=%0d uni=%0d, expected 0/123/3",
                  pronto, dado_lido, bcd_uni);
         miscompares++;
      end
   endtask

   task automatic test_rejection();
      logic e;
      req_in = 1'b1;
      tick();
      press_key(4'd9, e);
      press_key(4'd8, e);
      press_key(4'd7, e);
      press_key(4'd5, e);
      vectors++;
      if (e !== 1'b1) begin
         $display("[TB] FAIL erro_full: got %b, expected 1", e);
         miscompares++;
      end
      vectors++;
      if (erro !== 1'b0 || {bcd_cen, bcd_dez, bcd_uni} !== 12'h987) begin
         $display("[TB] FAIL erro_width_digits: erro=%b digits=%h%h%h, expected 0 987",
                  erro, bcd_cen, bcd_dez, bcd_uni);
         miscompares++;
      end
      press_key(COD_APAGA, e);
      vectors++;
      if (e !== 1'b0 || {bcd_cen, bcd_dez, bcd_uni} !== 12'h098) begin
         $display("[TB] FAIL apaga: erro=%b digits=%h%h%h, expected 0 098", e, bcd_cen, bcd_dez, bcd_uni);
         miscompares++;
      end
      press_key(4'hD, e);
      vectors++;
      if (e !== 1'b1 || {bcd_cen, bcd_dez, bcd_uni} !== 12'h098) begin
         $display("[TB] FAIL bad_code: erro=%b digits=%h%h%h, expected 1 098", e, bcd_cen, bcd_dez, bcd_uni);
         miscompares++;
      end
      press_key(4'd4, e);
      press_key(COD_ENTER, e);
      vectors++;
      if (pronto !== 1'b1 || dado_lido !== 32'd984) begin
         $display("[TB] FAIL deliver_984: pronto=%b dado_lido=%0d, expected 1/984", pronto, dado_lido);
         miscompares++;
      end
      req_in = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      logic e;
      req_in = 1'b1;
      tick();
      press_key(4'd5, e);
      vectors++;
      if (bcd_uni !== 4'd5) begin
         $display("[TB] FAIL abort_digit: got %0d, expected 5", bcd_uni);
         miscompares++;
      end
      req_in = 1'b0;
      dado_chaves = 4'd6;
      botao = 1'b1;
      tick();
      botao = 1'b0;
      tick();
      vectors++;
      if (aguardando !== 1'b0 || pronto !== 1'b0 || {bcd_cen, bcd_dez, bcd_uni} !== 12'h000
          || dado_lido !== 32'd984) begin
         $display("[TB] FAIL abort: aguardando=%b pronto=%b digits=%h%h%h dado_lido=%0d, expected 0/0/000/984",
                  aguardando, pronto, bcd_cen, bcd_dez, bcd_uni, dado_lido);
         miscompares++;
      end
   endtask

   task automatic test_empty_enter();
      logic e;
      req_in = 1'b1;
      tick();
      press_key(COD_ENTER, e);
      tick();
      vectors++;
      if (e !== 1'b1 || pronto !== 1'b0 || aguardando !== 1'b1) begin
         $display("[TB] FAIL empty_enter: erro=%b pronto=%b aguardando=%b, expected 1/0/1", e, pronto, aguardando);
         miscompares++;
      end
      press_key(COD_APAGA, e);
      vectors++;
      if (e !== 1'b1) begin
         $display("[TB] FAIL empty_apaga: erro=%b, expected 1", e);
         miscompares++;
      end
      press_key(4'd0, e);
      press_key(COD_ENTER, e);
      vectors++;
      if (pronto !== 1'b1 || dado_lido !== 32'd0) begin
         $display("[TB] FAIL deliver_0: pronto=%b dado_lido=%0d, expected 1/0", pronto, dado_lido);
         miscompares++;
      end
      req_in = 1'b0;
      tick();
   endtask

   task automatic test_held_button();
      logic e;
      dado_chaves = 4'd3;
      botao = 1'b1;
      tick();
      req_in = 1'b1;
      tick(); tick(); tick();
      vectors++;
      if (bcd_uni !== 4'd0 || erro !== 1'b0 || aguardando !== 1'b1) begin
         $display("[TB] FAIL held_button: uni=%0d erro=%b aguardando=%b, expected 0/0/1", bcd_uni, erro, aguardando);
         miscompares++;
      end
      botao = 1'b0;
      tick();
      press_key(4'd7, e);
      vectors++;
      if (bcd_uni !== 4'd7) begin
         $display("[TB] FAIL repress: uni=%0d, expected 7", bcd_uni);
         miscompares++;
      end
      press_key(COD_ENTER, e);
      vectors++;
      if (pronto !== 1'b1 || dado_lido !== 32'd7) begin
         $display("[TB] FAIL deliver_7: pronto=%b dado_lido=%0d, expected 1/7", pronto, dado_lido);
         miscompares++;
      end
      reset = 1'b0;
      tick();
      vectors++;
      if (pronto !== 1'b0 || dado_lido !== 32'd0 || bcd_uni !== 4'd0) begin
         $display("[TB] FAIL reset_in_entrega: pronto=%b dado_lido=%0d uni=%0d, expected 0/0/0",
                  pronto, dado_lido, bcd_uni);
         miscompares++;
      end
      reset = 1'b1;
      req_in = 1'b0;
      tick();
   endtask

   // Runs every scenario in order and prints the summary.
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      req_in      = 1'b0;
      botao       = 1'b0;
      dado_chaves = 4'd0;
      test_reset();
      test_basic_entry();
      test_rejection();
      test_abort();
      test_empty_enter();
      test_held_button();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
